// File: rtl/fifo_pkg.sv
// fifo_pkg: constants and types shared by sync_fifo, its drain stage
// (fifo_stream_reader / stream_skid_buf) and their benches.
//   DEFAULT_DATA_WIDTH / DEFAULT_PKT_LEN : default word width and packet length
//   SKID_DEPTH                           : entries in the drain skid buffer
//   word_t                               : one FIFO word at the default width
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_PKT_LEN    = 8;
    localparam int SKID_DEPTH         = 3;
    localparam int SKID_CNT_W         = 2;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;
    typedef logic [SKID_CNT_W-1:0]         skid_cnt_t;

    // Advance a skid-buffer pointer around the 3-entry ring.
    function automatic skid_cnt_t skid_ptr_inc(input skid_cnt_t p);
        return (p == skid_cnt_t'(SKID_DEPTH - 1)) ? skid_cnt_t'(0) : p + skid_cnt_t'(1);
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// stream_skid_buf: 3-entry circular buffer absorbing the FIFO read latency.
//   clk, reset     : clock, synchronous active-low reset
//   push/push_data : write push_data at the tail this cycle
//   pop            : remove the head entry this cycle (ignored when empty)
//   head_data      : oldest entry (meaningless when count == 0)
//   count          : occupancy 0..3
// A push and a pop in the same cycle leave count unchanged; a push into a
// full buffer is only honoured when a pop frees the slot in the same cycle.
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output skid_cnt_t             count
);

    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
    skid_cnt_t             head_q, head_d;
    skid_cnt_t             tail_q, tail_d;
    skid_cnt_t             count_q, count_d;
    logic                  pop_ok;
    logic                  push_ok;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pop_ok  = pop && (count_q != skid_cnt_t'(0));
        push_ok = push && ((count_q != skid_cnt_t'(SKID_DEPTH)) || pop_ok);

        if (push_ok) begin
            mem_d[tail_q] = push_data;
            tail_d        = skid_ptr_inc(tail_q);
        end
        if (pop_ok) begin
            head_d = skid_ptr_inc(head_q);
        end
        count_d = count_q + skid_cnt_t'(push_ok) - skid_cnt_t'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head_data = mem_q[head_q];
    assign count     = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a sync_fifo into a valid/ready stream framed
// into PKT_LEN-word packets.
//   clk, reset          : clock, synchronous active-low reset
//   fifo_dout           : FIFO data, valid the cycle after an accepted read
//   fifo_empty          : FIFO empty flag
//   fifo_read_en        : read request (from registered state + fifo_empty only)
//   out_data/out_valid  : stream word (skid head) and its valid
//   out_ready           : consumer accepts the word this cycle
//   out_last            : word is PKT_LEN-1 of its packet
//   pkt_count           : completed packets, wrapping
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PKT_LEN    = DEFAULT_PKT_LEN,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_read_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [CNT_WIDTH-1:0]  pkt_count
);

    localparam int                IDX_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PKT_LEN - 1);

    skid_cnt_t             occ;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  inflight_q, inflight_d;
    logic [IDX_W-1:0]      word_idx_q, word_idx_d;
    logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;
    logic                  handshake;

    // Reserve a skid slot for every read still in flight, so a returning
    // word always has room even if the consumer stalls; this keeps
    // out_ready out of the read-enable path.
    always_comb begin
        fifo_read_en = reset && !fifo_empty &&
                       (({1'b0, occ} + {2'b00, inflight_q}) < 3'd3);
        inflight_d   = fifo_read_en;
    end

    always_comb begin
        out_valid = (occ != skid_cnt_t'(0));
        out_last  = out_valid && (word_idx_q == LAST_IDX);
        out_data  = out_valid ? head_data : '0;
        handshake = out_valid && out_ready;
    end

    always_comb begin
        word_idx_d  = word_idx_q;
        pkt_count_d = pkt_count_q;
        if (handshake) begin
            word_idx_d = (word_idx_q == LAST_IDX) ? '0 : word_idx_q + IDX_W'(1);
            if (out_last) begin
                pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            inflight_q  <= 1'b0;
            word_idx_q  <= '0;
            pkt_count_q <= '0;
        end else begin
            inflight_q  <= inflight_d;
            word_idx_q  <= word_idx_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign pkt_count = pkt_count_q;

    // The word on fifo_dout is captured whenever the previous cycle issued a
    // read; during reset the buffer clears, dropping that word.
    stream_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (fifo_dout),
        .pop       (handshake),
        .head_data (head_data),
        .count     (occ)
    );

endmodule
